// File: rtl/cic_decim_multi.sv
// Multi-channel PDM-to-PCM CIC decimator: strobe-qualified per-channel integrators,
// one time-shared comb engine, and a {ch,data} output FIFO with sticky overrun.
module cic_decim_multi #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned ORDER      = 4,
    parameter int unsigned DECIM_LOG2 = 6,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pdm_valid_i,
    input  logic [CHANNELS-1:0] pdm_din_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CH_W-1:0]     out_ch_o,
    output logic [OUT_W-1:0]    out_data_o,
    output logic                overrun_o,
    input  logic                overrun_clr_i
);
    localparam int unsigned W     = ORDER * DECIM_LOG2 + 2;
    localparam int unsigned SHIFT = W - 1 - OUT_W;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PW1   = PTR_W + 1;
    localparam int unsigned E_W   = CH_W + OUT_W;
    localparam logic [W-1:0]    PLUS_ONE  = W'(1);
    localparam logic [W-1:0]    MINUS_ONE = '1;
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CHANNELS - 1);

    typedef enum logic {IDLE, RUN} state_e;

    logic [DECIM_LOG2-1:0] phase_q;
    logic [W-1:0]          integ_q [CHANNELS][ORDER];
    logic [W-1:0]          hold_q  [CHANNELS];
    logic [W-1:0]          dly_q   [CHANNELS][ORDER];
    logic [W-1:0]          comb_in [ORDER];
    logic [W-1:0]          comb_y;
    logic signed [W-1:0]   y_shr;
    logic [OUT_W-1:0]      sat_data;
    logic                  snap_c;
    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  push_c;

    logic [E_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PW1-1:0]        wr_q, rd_q, wr_d, rd_d, count_c;
    logic                  full_c, pop_c, wr_en_c, drop_c;
    logic [E_W-1:0]        entry_c, head_d;

    assign snap_c = pdm_valid_i && (phase_q == '1);

    // Integrator chain: every stage updates from the old value of its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hold_q[c] <= '0;
                for (int k = 0; k < ORDER; k++) integ_q[c][k] <= '0;
            end
        end else if (pdm_valid_i) begin
            phase_q <= phase_q + DECIM_LOG2'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                integ_q[c][0] <= integ_q[c][0] + (pdm_din_i[c] ? PLUS_ONE : MINUS_ONE);
                for (int k = 1; k < ORDER; k++) integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
                if (snap_c) hold_q[c] <= integ_q[c][ORDER-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // A snapshot landing on the last channel (CHANNELS == R) restarts RUN directly.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_c) begin
                    state_d = RUN;
                    ch_d    = '0;
                end
            end
            RUN: begin
                push_c = 1'b1;
                if (ch_q == CH_LAST) begin
                    ch_d    = '0;
                    state_d = snap_c ? RUN : IDLE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : comb_engine
        logic [W-1:0] x;
        x = hold_q[ch_q];
        for (int k = 0; k < ORDER; k++) begin
            comb_in[k] = x;
            x          = x - dly_q[ch_q][k];
        end
        comb_y = x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < ORDER; k++) dly_q[c][k] <= '0;
        end else if (push_c) begin
            for (int k = 0; k < ORDER; k++) dly_q[ch_q][k] <= comb_in[k];
        end
    end

    // Saturate when the bits above the output sign bit disagree with it.
    always_comb begin
        y_shr = $signed(comb_y) >>> SHIFT;
        if ((y_shr[W-1:OUT_W-1] == '0) || (y_shr[W-1:OUT_W-1] == '1))
            sat_data = y_shr[OUT_W-1:0];
        else if (y_shr[W-1])
            sat_data = {1'b1, {(OUT_W-1){1'b0}}};
        else
            sat_data = {1'b0, {(OUT_W-1){1'b1}}};
    end

    assign entry_c = {ch_q, sat_data};
    assign count_c = wr_q - rd_q;
    assign full_c  = (count_c == PW1'(FIFO_DEPTH));
    assign pop_c   = out_valid_o && out_ready_i;
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;
    assign wr_d    = wr_q + PW1'(wr_en_c);
    assign rd_d    = rd_q + PW1'(pop_c);

    // Next head bypasses the array when it is the entry being written.
    always_comb begin
        head_d = mem_q[rd_d[PTR_W-1:0]];
        if (wr_en_c && (wr_q[PTR_W-1:0] == rd_d[PTR_W-1:0])) head_d = entry_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            out_valid_o <= 1'b0;
            out_ch_o    <= '0;
            out_data_o  <= '0;
            overrun_o   <= 1'b0;
        end else begin
            if (wr_en_c) mem_q[wr_q[PTR_W-1:0]] <= entry_c;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            out_valid_o <= (wr_d != rd_d);
            out_ch_o    <= head_d[E_W-1:OUT_W];
            out_data_o  <= head_d[OUT_W-1:0];
            if (drop_c)             overrun_o <= 1'b1;
            else if (overrun_clr_i) overrun_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cic_decim_multi.sv
// Directed bench for cic_decim_multi: a timing model of strobes, pushes and FIFO
// occupancy feeds an expected-output queue checked at every consumer handshake.
module tb_cic_decim_multi;
    localparam int unsigned CHANNELS   = 2;
    localparam int unsigned ORDER      = 4;
    localparam int unsigned DECIM_LOG2 = 6;
    localparam int unsigned OUT_W      = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CH_W       = 1;
    localparam int unsigned R          = 1 << DECIM_LOG2;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [OUT_W-1:0] data;
        logic [1:0]       kind;   // 0: channel only, 1: exact data, 2: data within +-1
    } exp_t;

    typedef struct packed {
        logic [31:0] due;
        exp_t        e;
    } pend_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                pdm_valid_i = 1'b0;
    logic [CHANNELS-1:0] pdm_din_i = '0;
    logic                out_valid_o;
    logic                out_ready_i = 1'b0;
    logic [CH_W-1:0]     out_ch_o;
    logic [OUT_W-1:0]    out_data_o;
    logic                overrun_o;
    logic                overrun_clr_i = 1'b0;

    int   n_asrt = 0;
    int   n_fail = 0;
    exp_t sb[$];
    pend_t pend[$];
    int   phase = 0;
    int   fr = 0;
    int   edge_cnt = 0;
    logic exp_ovr = 1'b0;
    logic [1:0]       kind_mode = 2'd1;
    logic [OUT_W-1:0] exp_val [CHANNELS];

    cic_decim_multi #(
        .CHANNELS(CHANNELS), .ORDER(ORDER), .DECIM_LOG2(DECIM_LOG2),
        .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pdm_valid_i(pdm_valid_i), .pdm_din_i(pdm_din_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ch_o(out_ch_o),
        .out_data_o(out_data_o), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        pend.delete();
        phase   = 0;
        fr      = 0;
        exp_ovr = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        pdm_valid_i   = 1'b0;
        pdm_din_i     = '0;
        out_ready_i   = 1'b0;
        overrun_clr_i = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_ch", 32'(out_ch_o), 0);
        chk("rst_data", 32'(out_data_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        rst_n = 1'b1;
    endtask

    // One clock: resolve handshake, model push/drop, advance strobe phase, then check.
    task automatic tick();
        exp_t  e;
        pend_t p;
        logic  drop;
        if (out_valid_o && out_ready_i && (sb.size() != 0)) begin
            e = sb.pop_front();
            chk("out_ch", 32'(out_ch_o), 32'(e.ch));
            if (e.kind == 2'd1)
                chk("out_data", 32'(out_data_o), 32'(e.data));
            else if (e.kind == 2'd2)
                chk("out_data_tol",
                    32'(($signed(out_data_o) >= -16'sd1) && ($signed(out_data_o) <= 16'sd1)), 1);
        end
        drop = 1'b0;
        if ((pend.size() != 0) && (pend[0].due == 32'(edge_cnt + 1))) begin
            p = pend.pop_front();
            if (sb.size() < FIFO_DEPTH) sb.push_back(p.e);
            else drop = 1'b1;
        end
        if (pdm_valid_i) begin
            if (phase == R - 1) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    e.ch   = CH_W'(c);
                    e.data = exp_val[c];
                    e.kind = (fr >= ORDER) ? kind_mode : 2'd0;
                    p.due  = 32'(edge_cnt + 2 + c);
                    p.e    = e;
                    pend.push_back(p);
                end
                fr++;
            end
            phase = (phase + 1) % R;
        end
        if (drop) exp_ovr = 1'b1;
        else if (overrun_clr_i) exp_ovr = 1'b0;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        chk("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
        chk("overrun", 32'(overrun_o), 32'(exp_ovr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to_push(input int ch, input int min_fr, input string tag);
        int guard;
        guard = 0;
        while (!((pend.size() != 0) && (pend[0].due == 32'(edge_cnt + 1)) &&
                 (int'(pend[0].e.ch) == ch) && (fr >= min_fr)) && (guard < 4000)) begin
            tick();
            guard++;
        end
        chk(tag, 32'(guard < 4000), 1);
    endtask

    initial begin
        logic alt;
        int   guard;

        // All ones: settled frames saturate to +full scale on both channels
        reset_dut();
        exp_val[0] = 16'h7FFF; exp_val[1] = 16'h7FFF; kind_mode = 2'd1;
        pdm_din_i = '1; pdm_valid_i = 1'b1; out_ready_i = 1'b1;
        ticks(6 * R + 4);
        pdm_valid_i = 1'b0;
        ticks(4);

        // All zeros: -full scale
        reset_dut();
        exp_val[0] = 16'h8000; exp_val[1] = 16'h8000; kind_mode = 2'd1;
        pdm_din_i = '0; pdm_valid_i = 1'b1; out_ready_i = 1'b1;
        ticks(6 * R + 4);
        pdm_valid_i = 1'b0;
        ticks(4);

        // Alternating 1/0 per strobe: settles to zero within one LSB
        reset_dut();
        exp_val[0] = 16'h0000; exp_val[1] = 16'h0000; kind_mode = 2'd2;
        pdm_valid_i = 1'b1; out_ready_i = 1'b1; alt = 1'b1;
        for (int i = 0; i < 6 * R + 4; i++) begin
            pdm_din_i = alt ? '1 : '0;
            alt = ~alt;
            tick();
        end
        pdm_valid_i = 1'b0;
        ticks(4);

        // ch0 ones, ch1 zeros, strobe every third cycle
        reset_dut();
        exp_val[0] = 16'h7FFF; exp_val[1] = 16'h8000; kind_mode = 2'd1;
        pdm_din_i = 2'b01; out_ready_i = 1'b1;
        for (int i = 0; i < 6 * R * 3 + 6; i++) begin
            pdm_valid_i = (i % 3 == 0);
            tick();
        end
        pdm_valid_i = 1'b0;
        ticks(4);

        // Stalled consumer: six pushes into four entries, then drain and clear
        reset_dut();
        exp_val[0] = 16'h7FFF; exp_val[1] = 16'h7FFF; kind_mode = 2'd1;
        pdm_din_i = '1; pdm_valid_i = 1'b1; out_ready_i = 1'b0;
        guard = 0;
        while (!((fr == 3) && (pend.size() == 0)) && (guard < 4000)) begin
            tick();
            guard++;
        end
        chk("stall_timeout", 32'(guard < 4000), 1);
        pdm_valid_i = 1'b0;
        chk("stall_overrun", 32'(overrun_o), 1);
        chk("stall_valid", 32'(out_valid_o), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_head_ch", 32'(out_ch_o), 0);
        end
        out_ready_i = 1'b1;
        ticks(6);
        chk("drained_valid", 32'(out_valid_o), 0);
        chk("sticky_overrun", 32'(overrun_o), 1);
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        chk("cleared_overrun", 32'(overrun_o), 0);

        // Full FIFO with push and pop on the same edge: nothing dropped
        reset_dut();
        pdm_din_i = '1; pdm_valid_i = 1'b1; out_ready_i = 1'b0;
        run_to_push(0, 3, "full_timeout");
        out_ready_i = 1'b1;
        ticks(2);
        out_ready_i = 1'b0;
        pdm_valid_i = 1'b0;
        chk("full_no_overrun", 32'(overrun_o), 0);
        tick();
        out_ready_i = 1'b1;
        ticks(6);
        chk("full_drained", 32'(out_valid_o), 0);

        // Asynchronous reset between the ch0 and ch1 pushes
        reset_dut();
        pdm_din_i = '1; pdm_valid_i = 1'b1; out_ready_i = 1'b1;
        run_to_push(0, 1, "midrun_timeout");
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid_o), 0);
        chk("async_ch", 32'(out_ch_o), 0);
        chk("async_data", 32'(out_data_o), 0);
        chk("async_overrun", 32'(overrun_o), 0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(R);
        chk("post_rst_quiet", 32'(out_valid_o), 0);
        tick();
        chk("post_rst_first", 32'(out_valid_o), 1);
        chk("post_rst_ch", 32'(out_ch_o), 0);
        pdm_valid_i = 1'b0;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
